// File: rtl/du_pkg.sv
// Shared definitions for the debug unit: FSM encoding, byte width, default
// frame header and a counter-width helper.
package du_pkg;

  localparam int NB_BYTE_DEF = 8;
  localparam logic [7:0] HEADER_DEF = 8'hA5;

  localparam int NB_STATE = 3;
  localparam logic [NB_STATE-1:0] ST_IDLE      = 3'd0;
  localparam logic [NB_STATE-1:0] ST_LOAD_HDR  = 3'd1;
  localparam logic [NB_STATE-1:0] ST_WAIT      = 3'd2;
  localparam logic [NB_STATE-1:0] ST_LOAD_BYTE = 3'd3;
  localparam logic [NB_STATE-1:0] ST_LOAD_CKS  = 3'd4;
  localparam logic [NB_STATE-1:0] ST_DONE      = 3'd5;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  function automatic logic [NB_BYTE_DEF-1:0] cks_update(
    input logic [NB_BYTE_DEF-1:0] cks,
    input logic [NB_BYTE_DEF-1:0] data
  );
    return cks ^ data;
  endfunction

endpackage

// File: rtl/du_report_tx.sv
// Debug-unit report serializer: snapshots N_WORDS words and streams a
// header plus the payload bytes to uart_tx. DU_REPORT_CHECKSUM_EN appends an XOR checksum byte.
module du_report_tx
  import du_pkg::*;
#(
  parameter int                 NB_WORD = 32,
  parameter int                 N_WORDS = 4,
  parameter int                 NB_BYTE = NB_BYTE_DEF,
  parameter logic [NB_BYTE-1:0] HEADER  = NB_BYTE'(HEADER_DEF)
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [N_WORDS*NB_WORD-1:0] i_words,
  input  logic                       i_tx_done,
  output logic                       o_tx_start,
  output logic [NB_BYTE-1:0]         o_tx_data,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int SNAP_W = N_WORDS * NB_WORD;
  localparam int BPW    = NB_WORD / NB_BYTE;
  localparam int BCW    = cnt_width(BPW);
  localparam int WCW    = cnt_width(N_WORDS);

  localparam logic [BCW-1:0] BYTE_LAST = BCW'(BPW - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(N_WORDS - 1);

  logic [NB_STATE-1:0] state_q, state_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic [BCW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0]      word_cnt_q, word_cnt_d;
  logic                last_q, last_d;
  logic                tx_start_q, tx_start_d;
  logic [NB_BYTE-1:0]  tx_data_q, tx_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [31:0]         bit_sh_s;
  logic [NB_BYTE-1:0]  sel_byte_s;

`ifdef DU_REPORT_CHECKSUM_EN
  logic [NB_BYTE-1:0]  cks_q, cks_d;
  logic                cks_sent_q, cks_sent_d;
`endif

  // Next payload byte: word index picks the word, byte counter walks MSB first.
  always_comb begin
    bit_sh_s   = 32'(word_cnt_q) * 32'(NB_WORD) + 32'(BYTE_LAST - byte_cnt_q) * 32'(NB_BYTE);
    sel_byte_s = NB_BYTE'(snap_q >> bit_sh_s);
  end

  // FSM, snapshot, counters and output next-state logic.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    last_d     = last_q;
    tx_data_d  = tx_data_q;
`ifdef DU_REPORT_CHECKSUM_EN
    cks_d      = cks_q;
    cks_sent_d = cks_sent_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef DU_REPORT_CHECKSUM_EN
        cks_d      = '0;
        cks_sent_d = 1'b0;
`endif
        if (i_start) begin
          snap_d     = i_words;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          last_d     = 1'b0;
          tx_data_d  = HEADER;
          state_d    = ST_LOAD_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD_HDR: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (i_tx_done) begin
`ifdef DU_REPORT_CHECKSUM_EN
          if (cks_sent_q) begin
            state_d = ST_DONE;
          end else if (last_q) begin
            tx_data_d = cks_q;
            state_d   = ST_LOAD_CKS;
          end else begin
            tx_data_d = sel_byte_s;
            state_d   = ST_LOAD_BYTE;
          end
`else
          if (last_q) begin
            state_d = ST_DONE;
          end else begin
            tx_data_d = sel_byte_s;
            state_d   = ST_LOAD_BYTE;
          end
`endif
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_LOAD_BYTE: begin
`ifdef DU_REPORT_CHECKSUM_EN
        cks_d = cks_update(cks_q, tx_data_q);
`endif
        // last_q marks that the byte just loaded ends the payload.
        if (byte_cnt_q == BYTE_LAST) begin
          byte_cnt_d = '0;
          if (word_cnt_q == WORD_LAST) begin
            last_d = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end else begin
          byte_cnt_d = byte_cnt_q + BCW'(1);
        end
        state_d = ST_WAIT;
      end

`ifdef DU_REPORT_CHECKSUM_EN
      ST_LOAD_CKS: begin
        cks_sent_d = 1'b1;
        state_d    = ST_WAIT;
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tx_start_d = (state_d == ST_LOAD_HDR) || (state_d == ST_LOAD_BYTE) ||
                 (state_d == ST_LOAD_CKS);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // State, snapshot, counters and registered outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      snap_q     <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      last_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      last_q     <= last_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef DU_REPORT_CHECKSUM_EN
  // Running payload checksum and its sent flag.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cks_q      <= '0;
      cks_sent_q <= 1'b0;
    end else begin
      cks_q      <= cks_d;
      cks_sent_q <= cks_sent_d;
    end
  end
`endif

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_du_report_tx.sv
// Bench for du_report_tx: a 4x32 instance and a 1x16 instance driven from a
// table of report vectors, with a byte scoreboard and exact handshake timing.
module tb_du_report_tx;

  localparam bit CKS_EN =
`ifdef DU_REPORT_CHECKSUM_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    bit           sel;       // 0: 4x32 instance, 1: 1x16 instance
    logic [127:0] words;
    int           dly;       // idle WAIT cycles before i_tx_done
    bit           both;      // i_tx_done together with i_start
    bit           glitch;    // new words + i_start during the 5th byte
    int           abort_at;  // byte index whose WAIT gets a reset, -1 none
    int           len;       // bytes without checksum
    logic [7:0]   cks;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         tx_done = 1'b0;
  logic         sel = 1'b0;
  logic [127:0] words = '0;

  logic       tx_start0, busy0, done0, tx_start1, busy1, done1;
  logic [7:0] data0, data1;
  logic       tx_start_m, busy_m, done_m;
  logic [7:0] data_m;

  int tests = 0;
  int failed = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  du_report_tx dut0 (
    .i_clock(clk), .i_reset(rst), .i_start(start & ~sel), .i_words(words),
    .i_tx_done(tx_done & ~sel), .o_tx_start(tx_start0), .o_tx_data(data0),
    .o_busy(busy0), .o_done(done0)
  );

  du_report_tx #(.NB_WORD(16), .N_WORDS(1)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_start(start & sel), .i_words(words[15:0]),
    .i_tx_done(tx_done & sel), .o_tx_start(tx_start1), .o_tx_data(data1),
    .o_busy(busy1), .o_done(done1)
  );

  assign tx_start_m = sel ? tx_start1 : tx_start0;
  assign busy_m     = sel ? busy1 : busy0;
  assign done_m     = sel ? done1 : done0;
  assign data_m     = sel ? data1 : data0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input vec_t v);
    int nw;
    int bpw;
    nw  = v.sel ? 1 : 4;
    bpw = v.sel ? 2 : 4;
    exp_q.push_back(8'hA5);
    for (int wi = 0; wi < nw; wi++) begin
      for (int b = bpw - 1; b >= 0; b--) begin
        exp_q.push_back(v.words[(wi * bpw + b) * 8 +: 8]);
      end
    end
    if (CKS_EN) begin
      exp_q.push_back(v.cks);
    end
  endtask

  task automatic run_frame(input vec_t v);
    int n;
    logic [7:0] cur;
    n = v.len + (CKS_EN ? 1 : 0);
    @(negedge clk);
    sel   = v.sel;
    words = v.words;
    push_frame(v);
    start   = 1'b1;
    tx_done = v.both;
    @(negedge clk);
    start   = 1'b0;
    tx_done = 1'b0;
    check_bit("hdr_start_latency", tx_start_m, 1'b1);
    check_bit("busy_in_frame", busy_m, 1'b1);
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL scoreboard_underflow: byte %0d has no expected value", k);
        cur = 8'h00;
      end else begin
        cur = exp_q.pop_front();
      end
      check_byte($sformatf("byte%0d", k), data_m, cur);
      @(negedge clk);
      check_bit("start_one_cycle", tx_start_m, 1'b0);
      if (k == v.abort_at) begin
        #2 rst = 1'b1;
        #1;
        check_bit("rst_busy", busy_m, 1'b0);
        check_bit("rst_tx_start", tx_start_m, 1'b0);
        check_byte("rst_tx_data", data_m, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        return;
      end
      if (v.glitch && k == 4) begin
        words = ~v.words;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_byte("hold_after_glitch", data_m, cur);
      end
      repeat (v.dly) begin
        @(negedge clk);
        check_byte("data_hold", data_m, cur);
        check_bit("no_early_done", done_m, 1'b0);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      if (k < n - 1) begin
        check_bit("next_start_latency", tx_start_m, 1'b1);
      end else begin
        check_bit("done_pulse", done_m, 1'b1);
        check_bit("no_extra_start", tx_start_m, 1'b0);
      end
    end
    @(negedge clk);
    check_bit("done_one_cycle", done_m, 1'b0);
    check_bit("idle_after_done", busy_m, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check_bit("quiet_start", tx_start_m, 1'b0);
      check_bit("quiet_done", done_m, 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, {32'hFFFFFFFF, 32'h11001100, 32'h11223344, 32'hAABBCCDD}, 10, 1'b0, 1'b0, -1, 17, 8'h44};
    vecs[1] = '{1'b0, {32'hFFFFFFFF, 32'h11001100, 32'h11223344, 32'hAABBCCDD}, 10, 1'b0, 1'b1, -1, 17, 8'h44};
    vecs[2] = '{1'b0, {32'hFFFFFFFF, 32'h11001100, 32'h11223344, 32'hAABBCCDD}, 3, 1'b0, 1'b0, 2, 17, 8'h44};
    vecs[3] = '{1'b0, {32'hFFFFFFFF, 32'h11001100, 32'h11223344, 32'hAABBCCDD}, 2, 1'b0, 1'b0, -1, 17, 8'h44};
    vecs[4] = '{1'b0, {32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304}, 0, 1'b1, 1'b0, -1, 17, 8'h10};
    vecs[5] = '{1'b1, {112'h0, 16'hBEEF}, 1, 1'b0, 1'b0, -1, 3, 8'h51};
    vecs[6] = '{1'b1, {112'h0, 16'h1234}, 0, 1'b1, 1'b0, -1, 3, 8'h26};

    repeat (2) @(negedge clk);
    check_bit("reset_tx_start0", tx_start0, 1'b0);
    check_byte("reset_tx_data0", data0, 8'h00);
    check_bit("reset_busy0", busy0, 1'b0);
    check_bit("reset_done0", done0, 1'b0);
    check_bit("reset_busy1", busy1, 1'b0);
    check_byte("reset_tx_data1", data1, 8'h00);
    rst = 1'b0;

    // Stray done ticks in IDLE must not start anything.
    repeat (3) begin
      @(negedge clk);
      tx_done = 1'b1;
      check_bit("stray_done_start", tx_start_m, 1'b0);
      check_bit("stray_done_busy", busy_m, 1'b0);
    end
    @(negedge clk);
    tx_done = 1'b0;
    check_bit("stray_done_start_last", tx_start_m, 1'b0);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/du_report_tx.md
Name: du_report_tx

Overview:
- Parametrised report serializer for the debug unit.
- On a start pulse it snapshots N_WORDS debug words (PC, data memory, cycle count, registers, ...) and streams them as bytes to the UART transmitter.
- Uses a start/done byte handshake with the UART transmitter.
- Replaces the fixed four-constant hookup with a generic, width- and count-configurable stage that sits between the MIPS debug taps and uart_tx.

Parameters:
- NB_WORD, 32, width of each reported word; must be a multiple of NB_BYTE.
- N_WORDS, 4, number of words per report; valid range 1..64.
- NB_BYTE, 8, UART byte width.
- HEADER, 8'hA5, frame header byte sent before the payload.

Ports:
- i_clock  input  1  system clock.
- i_reset  input  1  asynchronous active-high reset.
- i_start  input  1  report request pulse; sampled only in IDLE.
- i_words  input  N_WORDS*NB_WORD  packed words; word 0 occupies bits [NB_WORD-1:0].
- i_tx_done  input  1  UART transmitter one-cycle done tick for the current byte.
- o_tx_start  output  1  one-cycle request to the UART to send o_tx_data.
- o_tx_data  output  NB_BYTE  byte to transmit; stable from o_tx_start until i_tx_done.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse when the report is complete.

Behaviour:
- Clock and reset: single clock, i_clock. i_reset is asynchronous and active-high. Reset forces state IDLE and clears every output, the snapshot register, the byte/word counters and the checksum.
- States:
  - IDLE: on i_start, latch i_words into the snapshot, clear counters, go to LOAD_HDR.
  - LOAD_HDR: drive o_tx_data=HEADER and o_tx_start=1 for one cycle; go to WAIT.
  - WAIT: hold o_tx_data.
    - On i_tx_done after the header or a non-final payload byte: go to LOAD_BYTE.
    - On i_tx_done after the final payload byte: go to DONE, or to LOAD_CKS if the checksum is enabled.
    - On i_tx_done after the checksum byte: go to DONE.
  - LOAD_BYTE: drive o_tx_data = selected byte, o_tx_start=1 for one cycle; advance counters; go to WAIT.
  - LOAD_CKS (optional): drive the checksum byte with o_tx_start; go to WAIT.
  - DONE: o_done=1 for one cycle; go to IDLE.
- Byte order:
  - Words go in index order 0..N_WORDS-1.
  - Within a word, bytes go MSB first.
  - Byte counter wraps at NB_WORD/NB_BYTE - 1, then the word index increments.
- Latency:
  - o_tx_start for the header is high in the cycle after i_start is sampled.
  - Each next o_tx_start is high in the cycle after i_tx_done is sampled.
  - o_done is high in the cycle after the final i_tx_done.
- Frame length: 1 + N_WORDS*NB_WORD/NB_BYTE bytes, plus 1 with the checksum enabled.
- Boundary cases:
  - i_start while busy: ignored; the snapshot is not updated.
  - i_tx_done outside WAIT: ignored.
  - i_start and i_tx_done together in IDLE: the start wins.
  - i_words changing mid-report: no effect, because the report uses the snapshot.
  - Reset mid-report: the frame is aborted immediately and o_tx_start deasserts asynchronously.
  - N_WORDS=1: valid; the last word is also the first.

Optional Feature:
- Macro: DU_REPORT_CHECKSUM_EN.
- Defined: the checksum is an NB_BYTE-wide XOR over all payload bytes, excluding the header. It is cleared in IDLE, accumulated in LOAD_BYTE, and sent as the final byte via LOAD_CKS.
- Undefined: LOAD_CKS and the checksum register are absent; WAIT after the last payload byte goes straight to DONE.

Decomposition:
- Shared package du_pkg holds:
  - the state encoding (IDLE, LOAD_HDR, WAIT, LOAD_BYTE, LOAD_CKS, DONE);
  - the default HEADER value;
  - NB_BYTE;
  - a clog2-based counter-width function.
- The debug_unit reuses the package.
- Sub-modules: none. The byte selection is a simple indexed part-select of the snapshot.

Test Plan:
- Normal report: N_WORDS=4, words {AABBCCDD, 11223344, 11001100, FFFFFFFF}, start, i_tx_done 10 cycles after each o_tx_start -> bytes A5 AA BB CC DD 11 22 33 44 11 00 11 00 FF FF FF FF. 17 o_tx_start pulses, then one o_done pulse.
- Checksum enabled, same stimulus -> 18 bytes; final byte 44.
- Snapshot/ignore: change i_words and pulse i_start during the 5th byte -> frame identical to the normal report; exactly one o_done.
- Reset mid-frame: assert i_reset during the WAIT for the 3rd byte -> o_busy=0, o_tx_start=0 and o_tx_data=00 immediately. A new start then begins with A5.
- Timing: i_tx_done arriving the same cycle as o_tx_start deasserts -> next o_tx_start exactly one cycle later. Stray i_tx_done pulses in IDLE produce no output.
- N_WORDS=1, NB_WORD=16, word 0xBEEF -> A5 BE EF, then o_done; with checksum, a trailing 51.
